program_loader: RTL and testbench

- Writer-side counterpart to the controller's opcode fetch path. The controller reads opcodes from the register-file memory; this block fills that memory with a program.
- Accepts a byte stream over a valid/ready handshake.
- Writes each byte into consecutive memory addresses, starting at a programmable base.
- Sits between an external host/loader interface and the register_file write port (address, in_data, wr). Active only while the controller's op is low, i.e. during user/load mode.

---
 rtl/program_loader.sv | 136 +++++++++++++
 tb/tb_program_loader.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Byte-stream program loader: writes a host byte stream into consecutive register_file addresses.
// Optional trailing two's-complement checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] start_address,
    input  logic [7:0]        length,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              checksum_ok,
    output logic [1:0]        state_dbg
);

    // Handshake: a byte transfers on a rising edge where in_valid && in_ready;
    // in_ready depends only on state and abort, never on in_valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHECK = 2'd2,
`endif
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [8:0]        remaining;
    logic              accept;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] sum_next;

    always_comb begin
        in_ready = 1'b0;
        if ((state == LOAD || state == CHECK) && !abort) in_ready = 1'b1;
    end

    assign sum_next = sum + in_data;
`else
    always_comb begin
        in_ready = 1'b0;
        if (state == LOAD && !abort) in_ready = 1'b1;
    end
`endif

    assign accept    = in_valid && in_ready;
    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            ptr         <= '0;
            remaining   <= 9'd0;
            mem_address <= '0;
            mem_data    <= '0;
            mem_wr      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            checksum_ok <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            sum         <= '0;
`endif
        end else begin
            // Write strobe is a single-cycle pulse per accepted byte.
            mem_wr <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        ptr         <= start_address;
                        remaining   <= (length == 8'd0) ? 9'd256 : {1'b0, length};
                        done        <= 1'b0;
                        checksum_ok <= 1'b0;
                        busy        <= 1'b1;
                        state       <= LOAD;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum         <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (accept) begin
                        mem_address <= ptr;
                        mem_data    <= in_data;
                        mem_wr      <= 1'b1;
                        ptr         <= ptr + 1'b1;
                        remaining   <= remaining - 9'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        sum         <= sum_next;
                        if (remaining == 9'd1) state <= CHECK;
`else
                        if (remaining == 9'd1) begin
                            state       <= DONE;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            checksum_ok <= 1'b1;
                        end
`endif
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                CHECK: begin
                    // The check byte is consumed but never written to memory.
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else if (accept) begin
                        checksum_ok <= (sum_next == '0);
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader with a write scoreboard; build with PROGRAM_LOADER_CHECKSUM_EN to cover the check byte.
module tb_program_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] start_address;
    logic [7:0]        length;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wr;
    logic              busy;
    logic              done;
    logic              checksum_ok;
    logic [1:0]        state_dbg;

    int checks = 0;
    int errors = 0;

    logic [15:0]       exp_q[$];
    logic              exp_wr;
    logic [ADDR_W-1:0] model_ptr;
    int                model_left;
    logic [7:0]        tb_sum;

    program_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .reset        (rst_n),
        .start        (start),
        .abort        (abort),
        .start_address(start_address),
        .length       (length),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_address  (mem_address),
        .mem_data     (mem_data),
        .mem_wr       (mem_wr),
        .busy         (busy),
        .done         (done),
        .checksum_ok  (checksum_ok),
        .state_dbg    (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    // scoreboard: the model predicts address/data at each handshake edge
    always @(posedge clk) begin
        exp_wr = 1'b0;
        if (rst_n && in_valid && in_ready && model_left > 0) begin
            exp_q.push_back({model_ptr, in_data});
            model_ptr  = model_ptr + 1'b1;
            model_left = model_left - 1;
            exp_wr     = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst_n) begin
            exp_q.delete();
            exp_wr = 1'b0;
        end else begin
            chk("mem_wr_timing", {31'd0, mem_wr}, {31'd0, exp_wr});
            if (mem_wr && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("write_addr_data", {16'd0, mem_address, mem_data}, {16'd0, e});
            end
        end
    end

    // drivers: all called just after a falling edge
    task automatic do_start(input logic [ADDR_W-1:0] base, input logic [7:0] len);
        start = 1'b1; start_address = base; length = len;
        model_ptr  = base;
        model_left = (len == 8'd0) ? 256 : int'(len);
        tb_sum     = 8'd0;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL send_timeout observed in_ready=0 expected in_ready=1 within 50 cycles");
        end
        tb_sum = tb_sum + d;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = 8'($urandom_range(0, 255));
        repeat (n) @(negedge clk);
    endtask

    task automatic end_load();
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send(8'(-tb_sum));
`endif
    endtask

    task automatic check_done(input string tag);
        #1;
        chk({tag, "_done"}, {31'd0, done}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_state"}, {30'd0, state_dbg}, {30'd0, ST_DONE});
        chk({tag, "_cksum"}, {31'd0, checksum_ok}, 32'd1);
        idle(1);
        chk({tag, "_drain"}, exp_q.size(), 32'd0);
    endtask

    initial begin
        rst_n = 1'b1; start = 1'b0; abort = 1'b0; start_address = '0; length = '0;
        in_valid = 1'b0; in_data = '0; model_ptr = '0; model_left = 0; tb_sum = '0;
        exp_wr = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        chk("rst_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
        chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("rst_addr", {24'd0, mem_address}, 32'd0);
        chk("rst_data", {24'd0, mem_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cksum", {31'd0, checksum_ok}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // basic streaming load
        do_start(8'h10, 8'd3);
        chk("t1_busy", {31'd0, busy}, 32'd1);
        send(8'hA1); send(8'hB2); send(8'hC3);
        end_load();
        check_done("t1");

        // address wrap
        do_start(8'hFE, 8'd4);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        end_load();
        check_done("t2");

        // length 0 means 256 bytes
        do_start(8'h00, 8'd0);
        for (int i = 0; i < 256; i++) begin
            if (i == 255) begin
                chk("t3_not_done", {31'd0, done}, 32'd0);
                chk("t3_busy", {31'd0, busy}, 32'd1);
            end
            send(8'(i));
        end
        end_load();
        check_done("t3");

        // gapped valid: 1,0,0,1,0,1
        do_start(8'h30, 8'd3);
        send(8'h5A); idle(2); send(8'h6B); idle(1); send(8'h7C);
        end_load();
        check_done("t4");

        // abort on the second byte
        do_start(8'h50, 8'd4);
        send(8'h11);
        in_valid = 1'b1; in_data = 8'h22; abort = 1'b1;
        #1 chk("t5_abort_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        abort = 1'b0; in_valid = 1'b0;
        chk("t5_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
        chk("t5_done", {31'd0, done}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        idle(2);
        chk("t5_drain", exp_q.size(), 32'd0);
        do_start(8'h60, 8'd2);
        send(8'h33); send(8'h44);
        end_load();
        check_done("t5b");

        // reset mid-load drops the strobe asynchronously
        do_start(8'h80, 8'd4);
        send(8'h99);
        rst_n = 1'b0;
        #1;
        chk("t6_mem_wr", {31'd0, mem_wr}, 32'd0);
        chk("t6_state", {30'd0, state_dbg}, {30'd0, ST_IDLE});
        chk("t6_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        // good and bad checksums
        do_start(8'h20, 8'd2);
        send(8'h05); send(8'h0A); send(8'hF1);
        check_done("t7");
        do_start(8'h20, 8'd2);
        send(8'h05); send(8'h0A); send(8'hF0);
        #1;
        chk("t8_done", {31'd0, done}, 32'd1);
        chk("t8_cksum", {31'd0, checksum_ok}, 32'd0);
        idle(1);
        chk("t8_drain", exp_q.size(), 32'd0);
`endif

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
